seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. Holds a displayed value and steps through the digits one at a time. Per digit slot it drives the 4-bit hex nibble to the downstream seven-segment lookup and drives one active-low anode. New values are staged and committed only at frame boundaries, so a frame never mixes old and new digits; a blanking gap at the start of each slot suppresses ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8.
PRESCALE, 100000, clk cycles per digit slot; legal >= 2.
BLANK_CYCLES, 1000, cycles at start of each slot with all anodes off; legal 0..PRESCALE-1.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
value_in  in  4*NUM_DIGITS  value to display; nibble i drives digit i; digit 0 is least significant and rightmost.
dp_in  in  NUM_DIGITS  decimal point request per digit, active high.
load  in  1  single-cycle strobe; captures value_in and dp_in.
pending  out  1  high while a captured value has not yet been committed to the display.
digit_num  out  4  hex nibble of the current digit; feeds the lookup num input.
an_n  out  NUM_DIGITS  anode enables, active low; at most one bit low.
dp_n  out  1  decimal point for the current digit, active low.
frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Single clock domain; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - slot_cnt = 0, digit_idx = 0.
  - shadow value/dp = 0; staged value/dp = 0.
  - pending = 0, digit_num = 0, an_n = all 1, dp_n = 1, frame_start = 0.
- slot_cnt counts 0..PRESCALE-1 and wraps. On wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
- Frame boundary (FB): the cycle where slot_cnt = PRESCALE-1 and digit_idx = NUM_DIGITS-1.
- All outputs are registered and reflect the counter/shadow state of the same cycle's next-state values. They change on the same edge as the counters.
  - an_n[i] = 0 iff i = digit_idx and slot_cnt >= BLANK_CYCLES; otherwise all bits are 1.
  - digit_num = shadow nibble[digit_idx]. It is valid for the whole slot, including blank.
  - dp_n = ~shadow_dp[digit_idx] while the anode is lit; otherwise 1.
  - frame_start = 1 for the single cycle in which digit_idx becomes 0 with slot_cnt = 0.
- Load/commit rules:
  - load, not on FB: staged <= value_in/dp_in; pending <= 1.
  - load while pending = 1: overwrites staged; last write wins.
  - FB with pending = 1 and no load: shadow <= staged; pending <= 0.
  - load on FB: bypass; shadow <= value_in/dp_in directly; pending stays/becomes 0.
- The committed value is first shown in the slot of digit 0 following FB.
- rst mid-slot: the next cycle shows reset values, which blanks all anodes; staged and pending are lost.
- No input handshake back-pressure; load is always accepted.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: digit i (i > 0) is kept dark (an_n[i] = 1, dp_n = 1) when shadow nibbles i..NUM_DIGITS-1 are all zero and shadow_dp[i] = 0. Digit 0 is always lit. The digit still consumes its slot time, so scan timing is unchanged.
- Undefined: every digit is lit in its slot.

Decomposition:
- Package seven_seg_pkg holds:
  - nibble typedef (4 bits);
  - ANODE_OFF / DP_OFF constants (1);
  - default NUM_DIGITS.
- One sub-module, scan_tick_gen: a PRESCALE/BLANK slot counter that outputs slot_end and lit_window. The digit index, shadow/staged registers and output decode stay in the top.

Test Plan:
All cases use PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=4.
1. Reset: hold rst 3 cycles -> an_n=1111, dp_n=1, pending=0, digit_num=0 throughout; after release, an_n[0] goes low at slot_cnt=2; frame_start pulses every 32 cycles.
2. load 16'h1234, dp_in=4'b0010, mid-frame -> pending=1 until FB. Next frame:
   - digit_num sequence 4,3,2,1 with an_n 1110,1101,1011,0111;
   - each digit dark 2 cycles, then lit 6;
   - dp_n=0 only during digit 1's lit window.
3. load 16'hAAAA, then load 16'h5555 three cycles later, same frame -> next frame shows 5,5,5,5; digit_num never shows A after commit.
4. load 16'hBEEF on the FB cycle -> pending never rises; the immediately following frame shows F,E,E,B.
5. rst asserted while an_n=1011 -> next cycle an_n=1111, shadow=0; after release, digits show 0.
6. With LEADING_ZERO_BLANK_EN:
   - 16'h0050 -> only an_n[0] and an_n[1] ever go low;
   - 16'h0000 -> only an_n[0] goes low;
   - 16'h0050 with dp_in=4'b1000 -> digits 0,1,3 lit, digit 2 dark.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic ANODE_OFF = 1'b1;
    localparam logic DP_OFF    = 1'b1;

    localparam int unsigned DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/seven_seg_scanner_scan_tick_gen.sv
// Digit-slot timer: counts PRESCALE cycles per slot and flags the slot end and
// whether the next cycle falls inside the lit (post-blanking) window.
module scan_tick_gen #(
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic lit_next
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;

    assign slot_end = (slot_cnt_q == CNT_W'(PRESCALE - 1));

    always_comb begin
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
        // Outputs downstream are registered from next-state, so judge the window on slot_cnt_d.
        lit_next   = (32'(slot_cnt_d) >= BLANK_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scan controller with frame-aligned commit.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    pending,
    output logic [3:0]              digit_num,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic slot_end;
    logic lit_next;

    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] staged_val_q, staged_val_d;
    logic [NUM_DIGITS-1:0]   staged_dp_q, staged_dp_d;
    logic                    pending_q, pending_d;
    nibble_t                 digit_num_q, digit_num_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q, frame_start_d;

    logic                    frame_bound;
    logic [NUM_DIGITS-1:0]   dark;
    logic                    zero_above;
    logic                    sel_dp;
    logic                    sel_dark;
    logic                    lit;

    scan_tick_gen #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .lit_next (lit_next)
    );

    assign frame_bound = slot_end && (digit_idx_q == LAST_IDX);

    // Digit index and load/commit handling.
    always_comb begin
        digit_idx_d  = digit_idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        staged_val_d = staged_val_q;
        staged_dp_d  = staged_dp_q;
        pending_d    = pending_q;

        if (slot_end) begin
            digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + 1'b1;
        end

        if (load && frame_bound) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b0;
        end else if (load) begin
            staged_val_d = value_in;
            staged_dp_d  = dp_in;
            pending_d    = 1'b1;
        end else if (frame_bound && pending_q) begin
            shadow_val_d = staged_val_q;
            shadow_dp_d  = staged_dp_q;
            pending_d    = 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit stays dark when it and everything above it is zero with no dp request.
    always_comb begin
        dark       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shadow_val_d[4*i +: 4] == 4'h0);
            dark[i]    = (i > 0) && zero_above && !shadow_dp_d[i];
        end
    end
`else
    always_comb begin
        dark       = '0;
        zero_above = 1'b0;
    end
`endif

    // Output decode from next-state so outputs move on the same edge as the counters.
    always_comb begin
        digit_num_d = '0;
        sel_dp      = 1'b0;
        sel_dark    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == digit_idx_d) begin
                digit_num_d = shadow_val_d[4*i +: 4];
                sel_dp      = shadow_dp_d[i];
                sel_dark    = dark[i];
            end
        end

        lit    = lit_next && !sel_dark;
        an_n_d = {NUM_DIGITS{ANODE_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (IDX_W'(i) == digit_idx_d)) begin
                an_n_d[i] = 1'b0;
            end
        end

        dp_n_d        = lit ? ~sel_dp : DP_OFF;
        frame_start_d = frame_bound;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx_q   <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            staged_val_q  <= '0;
            staged_dp_q   <= '0;
            pending_q     <= 1'b0;
            digit_num_q   <= '0;
            an_n_q        <= {NUM_DIGITS{ANODE_OFF}};
            dp_n_q        <= DP_OFF;
            frame_start_q <= 1'b0;
        end else begin
            digit_idx_q   <= digit_idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            staged_val_q  <= staged_val_d;
            staged_dp_q   <= staged_dp_d;
            pending_q     <= pending_d;
            digit_num_q   <= digit_num_d;
            an_n_q        <= an_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pending     = pending_q;
    assign digit_num   = digit_num_q;
    assign an_n        = an_n_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule
